// File: rtl/gc_multilane_scheduler.sv
// Gate-issue controller: walks gid per sequential cycle, retires free-XOR gates inline and spreads
// the rest round-robin over NE GC-engine lanes. Stall counters exist when GC_SCHED_PERF_EN is defined.
module gc_sched_lane #(
  parameter int II = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic busy
);
  localparam int BW = $clog2(II + 1);

  logic [BW-1:0] cnt;

  // The issue cycle itself is the first busy cycle, so II-1 more remain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt <= '0;
    else if (issue)      cnt <= BW'(II - 1);
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0);
endmodule

module gc_multilane_scheduler #(
  parameter int S   = 20,
  parameter int C_W = 16,
  parameter int NE  = 4,
  parameter int II  = 10,
  parameter int LAT = 11
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [C_W-1:0] cc_num,
  input  logic [S-1:0]   gate_size,
  input  logic           nl_ready,
  input  logic [3:0]     g_logic,
  input  logic           lbl_ready,
  output logic [S-1:0]   gid,
  output logic [C_W-1:0] cid,
  output logic           const_wr,
  output logic           xor_wr_en,
  output logic [NE-1:0]  issue_vld,
  output logic           gt_wr_en,
  output logic [2:0]     gt_lane,
  output logic [S-1:0]   ol_wr_addr,
  output logic [S-1:0]   gt_idx,
  output logic           done,
  output logic [31:0]    stall_lbl,
  output logic [31:0]    stall_lane
);
  // Gate types are 4-bit truth tables.
  localparam logic [3:0] XORGATE  = 4'b0110;
  localparam logic [3:0] XNORGATE = 4'b1001;
  localparam logic [3:0] NOTGATE  = 4'b0011;

  typedef enum logic [2:0] {ST_IDLE, ST_INIT, ST_WAIT, ST_GARBLE, ST_DRAIN, ST_DONE} state_t;

  state_t state, state_n;
  logic [S-1:0]   gid_n, and_cnt;
  logic [C_W-1:0] cid_n;
  logic [C_W:0]   cc_eff, cid_inc;
  logic [2:0]     rr, sel;
  logic           found, is_free, issue_any, clr;
  logic [NE-1:0]  lane_busy;

  logic [LAT-1:0]          vld_pipe;
  logic [LAT-1:0][2:0]     lane_pipe;
  logic [LAT-1:0][S-1:0]   gid_pipe, idx_pipe;

  assign is_free = (g_logic == XORGATE) || (g_logic == XNORGATE) || (g_logic == NOTGATE);
  assign cc_eff  = (cc_num == '0) ? {{C_W{1'b0}}, 1'b1} : {1'b0, cc_num};
  assign cid_inc = {1'b0, cid} + 1'b1;

  // Lowest free lane at or after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    sel   = 3'd0;
    for (int k = 0; k < NE; k++) begin
      for (int l = 0; l < NE; l++) begin
        if (!found && (l == (int'(rr) + k) % NE) && !lane_busy[l]) begin
          found = 1'b1;
          sel   = 3'(l);
        end
      end
    end
  end

  for (genvar i = 0; i < NE; i++) begin : g_lane
    assign issue_vld[i] = issue_any && (sel == 3'(i));
    gc_sched_lane #(.II(II)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .issue (issue_vld[i]),
      .busy  (lane_busy[i])
    );
  end

  always_comb begin
    state_n   = state;
    gid_n     = gid;
    cid_n     = cid;
    const_wr  = 1'b0;
    xor_wr_en = 1'b0;
    issue_any = 1'b0;
    clr       = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: if (start) begin
        state_n = ST_INIT;
        gid_n   = '0;
        cid_n   = '0;
        clr     = 1'b1;
      end
      ST_INIT: begin
        const_wr = 1'b1;
        state_n  = nl_ready ? ST_GARBLE : ST_WAIT;
      end
      ST_WAIT: if (nl_ready) state_n = ST_GARBLE;
      ST_GARBLE: begin
        if (gid < gate_size) begin
          if (lbl_ready && (is_free || found)) begin
            gid_n     = gid + 1'b1;
            xor_wr_en = is_free;
            issue_any = !is_free;
          end
        end else begin
          state_n = ST_DRAIN;
        end
      end
      // Hold until every lane result has been written back.
      ST_DRAIN: if (vld_pipe == '0) begin
        if (cid_inc < cc_eff) begin
          state_n = ST_GARBLE;
          gid_n   = '0;
          cid_n   = cid + 1'b1;
        end else begin
          state_n = ST_DONE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      gid     <= '0;
      cid     <= '0;
      and_cnt <= '0;
      rr      <= 3'd0;
    end else begin
      state <= state_n;
      gid   <= gid_n;
      cid   <= cid_n;
      if (clr) begin
        and_cnt <= '0;
        rr      <= 3'd0;
      end else if (issue_any) begin
        and_cnt <= and_cnt + 1'b1;
        rr      <= (sel == 3'(NE - 1)) ? 3'd0 : sel + 3'd1;
      end
    end
  end

  // One issue per cycle, so a single shared LAT-deep pipe tracks every in-flight result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      lane_pipe <= '0;
      gid_pipe  <= '0;
      idx_pipe  <= '0;
    end else begin
      vld_pipe[0]  <= issue_any;
      lane_pipe[0] <= sel;
      gid_pipe[0]  <= gid;
      idx_pipe[0]  <= and_cnt;
      for (int k = 1; k < LAT; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        lane_pipe[k] <= lane_pipe[k-1];
        gid_pipe[k]  <= gid_pipe[k-1];
        idx_pipe[k]  <= idx_pipe[k-1];
      end
    end
  end

  assign gt_wr_en   = vld_pipe[LAT-1];
  assign gt_lane    = gt_wr_en ? lane_pipe[LAT-1] : 3'd0;
  assign ol_wr_addr = gt_wr_en ? gid_pipe[LAT-1]  : '0;
  assign gt_idx     = gt_wr_en ? idx_pipe[LAT-1]  : '0;
  assign done       = (state == ST_DONE);

`ifdef GC_SCHED_PERF_EN
  logic pend_gate, stall_l, stall_n;

  assign pend_gate = (state == ST_GARBLE) && (gid < gate_size);
  assign stall_l   = pend_gate && !lbl_ready;
  assign stall_n   = pend_gate && lbl_ready && !is_free && !found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_lbl  <= '0;
      stall_lane <= '0;
    end else if (clr) begin
      stall_lbl  <= '0;
      stall_lane <= '0;
    end else begin
      if (stall_l && !(&stall_lbl))  stall_lbl  <= stall_lbl + 1'b1;
      if (stall_n && !(&stall_lane)) stall_lane <= stall_lane + 1'b1;
    end
  end
`else
  assign stall_lbl  = '0;
  assign stall_lane = '0;
`endif
endmodule
